// File: rtl/canvas_pkg.sv
// Shared constants, state encoding and address helper for the canvas write path.
package canvas_pkg;

    localparam int unsigned CANVAS_W      = 96;
    localparam int unsigned CANVAS_H      = 64;
    localparam int unsigned CANVAS_PIXELS = CANVAS_W * CANVAS_H;

    localparam logic [15:0] WHITE      = 16'hFFFF;
    localparam logic [15:0] NEON_GREEN = 16'b00111_111111_00010;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        BRUSH0,
        BRUSH1,
        STAMP
    } state_t;

    // Row-major pixel address; callers guarantee x < w and y < canvas height.
    function automatic logic [12:0] pix_addr(input logic [6:0] x,
                                             input logic [6:0] y,
                                             input int unsigned w);
        return 13'(y) * 13'(w) + 13'(x);
    endfunction

endpackage

// File: rtl/canvas_write_ctrl_stamp_oneshot.sv
// One-shot stamp request: rising-edge detect, re-arm lockout and pending flag.
module stamp_oneshot #(
    parameter int unsigned LOCKOUT = 500
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic stamp_btn,
    input  logic consume,
    input  logic discard,
    output logic stamp_pend
);

    localparam int unsigned CW = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;

    logic          stamp_btn_q;
    logic [CW-1:0] lockout;
    logic          rise;

    assign rise = stamp_btn & ~stamp_btn_q;

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            stamp_btn_q <= 1'b0;
            lockout     <= '0;
            stamp_pend  <= 1'b0;
        end else begin
            stamp_btn_q <= stamp_btn;

            if (consume)
                lockout <= CW'(LOCKOUT - 1);
            else if (lockout != '0)
                lockout <= lockout - CW'(1);

            // A service or a fill start wins over an edge arriving the same cycle.
            if (consume || discard)
                stamp_pend <= 1'b0;
            else if (rise && lockout == '0)
                stamp_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/canvas_write_ctrl.sv
// Arbitrates clear fill, brush stroke and stamp onto the single canvas write port.
module canvas_write_ctrl
    import canvas_pkg::*;
#(
    parameter int unsigned WIDTH   = CANVAS_W,
    parameter int unsigned HEIGHT  = CANVAS_H,
    parameter int unsigned LOCKOUT = 500
) (
    input  logic        CLOCK,
    input  logic        reset,
    input  logic        clear_req,
    input  logic [15:0] clear_colour,
    input  logic        brush_en,
    input  logic        stamp_btn,
    input  logic [6:0]  cursor_x,
    input  logic [5:0]  cursor_y,
    input  logic [15:0] brush_colour,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        clear_done
);

    localparam logic [12:0] ADDR_LAST = 13'(WIDTH * HEIGHT - 1);

    state_t      state, state_next;
    logic [12:0] fill_addr;
    logic        fill_last;
    logic [6:0]  cap_x;
    logic [5:0]  cap_y;
    logic [6:0]  cap_y1;
    logic [15:0] cap_colour;
    logic        x_ok, y_ok, y1_ok;
    logic        nxt_en;
    logic [12:0] nxt_addr;
    logic [15:0] nxt_data;
    logic        stamp_pend;
    logic        consume;
    logic        discard;

    assign cap_y1  = {1'b0, cap_y} + 7'd1;
    assign x_ok    = 32'(cap_x)  < WIDTH;
    assign y_ok    = 32'(cap_y)  < HEIGHT;
    assign y1_ok   = 32'(cap_y1) < HEIGHT;
    assign consume = (state == STAMP);
    assign discard = (state == CLEAR) || (state == IDLE && clear_req);

    stamp_oneshot #(
        .LOCKOUT(LOCKOUT)
    ) u_stamp (
        .CLOCK      (CLOCK),
        .reset      (reset),
        .stamp_btn  (stamp_btn),
        .consume    (consume),
        .discard    (discard),
        .stamp_pend (stamp_pend)
    );

    always_ff @(posedge CLOCK) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state plus the write that the output registers will present next cycle.
    always_comb begin
        state_next = state;
        nxt_en     = 1'b0;
        nxt_addr   = wr_addr;
        nxt_data   = wr_data;
        case (state)
            IDLE: begin
                if (clear_req)
                    state_next = CLEAR;
                else if (brush_en)
                    state_next = BRUSH0;
                else if (stamp_pend)
                    state_next = STAMP;
            end
            CLEAR: begin
                nxt_en   = 1'b1;
                nxt_addr = fill_addr;
                nxt_data = clear_colour;
                if (fill_addr == ADDR_LAST)
                    state_next = IDLE;
            end
            BRUSH0, STAMP: begin
                if (x_ok && y_ok) begin
                    nxt_en   = 1'b1;
                    nxt_addr = pix_addr(cap_x, {1'b0, cap_y}, WIDTH);
                    nxt_data = cap_colour;
                end
                state_next = (state == BRUSH0) ? BRUSH1 : IDLE;
            end
            BRUSH1: begin
                if (x_ok && y1_ok) begin
                    nxt_en   = 1'b1;
                    nxt_addr = pix_addr(cap_x, cap_y1, WIDTH);
                    nxt_data = cap_colour;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            fill_addr  <= '0;
            fill_last  <= 1'b0;
            cap_x      <= '0;
            cap_y      <= '0;
            cap_colour <= '0;
        end else begin
            wr_en      <= nxt_en;
            wr_addr    <= nxt_addr;
            wr_data    <= nxt_data;
            busy       <= (state != IDLE);
            fill_last  <= (state == CLEAR) && (fill_addr == ADDR_LAST);
            clear_done <= fill_last;

            if (state == CLEAR)
                fill_addr <= fill_addr + 13'd1;
            else
                fill_addr <= '0;

            // Captured every idle cycle, so the values seen on the entry edge are held.
            if (state == IDLE) begin
                cap_x      <= cursor_x;
                cap_y      <= cursor_y;
                cap_colour <= brush_colour;
            end
        end
    end

endmodule

// File: doc/canvas_write_ctrl.md
# canvas_write_ctrl

Sequencer and arbiter for the single write port of the 96×64 RGB565 canvas frame buffer. Three requesters share the port: full-canvas clear/background fill, continuous brush (2-pixel vertical stroke at the cursor) and one-shot stamp (single pixel per button press, with lockout). The block sits between the switch/button/cursor logic and the canvas memory. It issues at most one pixel write per clock.

## Interface
Parameters:
- WIDTH, 96, canvas width in pixels
- HEIGHT, 64, canvas height in pixels
- LOCKOUT, 500, stamp re-arm delay in clocks after a stamp write

Ports:
- CLOCK  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clear_req  in  1  level or pulse; request full-canvas fill
- clear_colour  in  16  fill colour, sampled every write cycle of the fill
- brush_en  in  1  level; continuous brush drawing
- stamp_btn  in  1  raw button level (already synchronised)
- cursor_x  in  7  cursor column
- cursor_y  in  6  cursor row
- brush_colour  in  16  colour for brush and stamp writes
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  13  y*WIDTH + x
- wr_data  out  16  pixel colour
- busy  out  1  high in any state other than IDLE
- clear_done  out  1  one-cycle pulse after the last fill write

## Operation
- States: IDLE, CLEAR, BRUSH0, BRUSH1, STAMP.
- Arbitration in IDLE, fixed priority: clear_req > brush_en > pending stamp.
- CLEAR:
  - Writes addresses 0..WIDTH*HEIGHT-1 (0..6143) ascending, one per cycle, with wr_data = clear_colour.
  - After writing address 6143, returns to IDLE and pulses clear_done.
  - clear_req, brush_en and stamp are ignored while in CLEAR.
  - Entering CLEAR discards any pending stamp.
- BRUSH0/BRUSH1:
  - cursor_x, cursor_y and brush_colour are captured on entry.
  - BRUSH0 writes (x, y). BRUSH1 writes (x, y+1).
  - If y == HEIGHT-1, BRUSH1 is skipped: wr_en is low that cycle and the state still returns to IDLE.
  - With brush_en held high, the block repeats IDLE→BRUSH0→BRUSH1 (3-cycle period).
- Stamp:
  - A rising edge of stamp_btn (stamp_btn & ~stamp_btn_q) sets stamp_pend, but only if the lockout counter is 0.
  - STAMP writes one pixel at the captured (x, y), clears stamp_pend and loads the lockout counter with LOCKOUT-1.
  - The counter decrements every cycle in every state. Edges that arrive while it is nonzero are dropped.
- Out-of-range cursor (x ≥ WIDTH or y ≥ HEIGHT): the brush or stamp pass runs, wr_en stays low, and a pending stamp is consumed.
- Address arithmetic: wr_addr = y*96 + x, 13 bits, never exceeds 6143.

## Timing
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, clear_done=0, state=IDLE, stamp_pend=0, lockout=0, stamp_btn_q=0.
- Latency:
  - Request seen in IDLE at edge n → first wr_en high in the cycle after edge n+1.
  - Fill: 6144 consecutive write cycles; clear_done is high in the cycle following the last write.
  - busy rises with the first write and falls with clear_done.
- Simultaneous clear_req and brush_en: CLEAR wins. Brush is re-evaluated after clear_done.
- Simultaneous stamp edge and brush_en: stamp_pend is set and serviced on the first IDLE cycle with brush_en low.
- Reset during CLEAR or BRUSH: the next cycle has wr_en=0 and state IDLE. The fill is not resumed.
- Lockout counter wrap: it saturates at 0 and never wraps.

## Structure
- Package canvas_pkg:
  - CANVAS_W=96, CANVAS_H=64, CANVAS_PIXELS=6144
  - state enum
  - colour constants WHITE=16'hFFFF, NEON_GREEN=16'b00111_111111_00010
- Sub-module stamp_oneshot: edge detect, lockout counter and stamp_pend flag. Its interface is a stamp_pend output and a consume input.

## Test plan
- Reset, then clear_req pulse with clear_colour=16'hFFFF → 6144 writes, addresses 0..6143, data FFFF, clear_done exactly once in the cycle after address 6143.
- brush_en=1, cursor (10,5), brush_colour=16'hF800 → repeating writes at 490 then 586, 3-cycle period. Cursor (10,63) → only 6058 is written, never 6154.
- stamp_btn held high for 2000 cycles at cursor (0,0) → exactly one write at addr 0. Second press 100 cycles after the write → no write. Press at 600 cycles → one write.
- clear_req and brush_en asserted in the same cycle → the fill runs first, and the brush writes start after clear_done.
- reset asserted at fill address 3000 → wr_en low on the next cycle, busy=0, no clear_done. A later clear_req restarts from address 0.
- cursor (96,10) with a stamp press → no write, lockout loaded, stamp_pend cleared.
